// File: rtl/char_buf_pkg.sv
// Shared definitions for the 80x60 VGA character buffer: screen geometry,
// fill character, arbiter state encoding and grant encoding.
package char_buf_pkg;

  localparam int TEXT_COLS   = 80;
  localparam int TEXT_ROWS   = 60;
  localparam int TEXT_CELLS  = TEXT_COLS * TEXT_ROWS;
  localparam int TEXT_ADDR_W = 13;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_t;

endpackage

// File: rtl/char_wr_arbiter_if.sv
// Bundle of requester handshakes, clear control and character-buffer write
// port. The slave modport is the arbiter's view, master is the surrounding logic.
interface char_wr_arbiter_if #(
  parameter int ADDR_W = 13
);

  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [7:0]        a_data;
  logic              a_ready;

  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [7:0]        b_data;
  logic              b_ready;

  logic              clr_req;
  logic              clr_busy;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport slave (
    input  a_valid, a_addr, a_data,
    output a_ready,
    input  b_valid, b_addr, b_data,
    output b_ready,
    input  clr_req,
    output clr_busy,
    output wr_en, wr_addr, wr_data
  );

  modport master (
    output a_valid, a_addr, a_data,
    input  a_ready,
    output b_valid, b_addr, b_data,
    input  b_ready,
    output clr_req,
    input  clr_busy,
    input  wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/char_wr_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone request wins outright, a tie goes to
// the requester that was not granted last. last_grant moves only on a grant.
module rr_arb2
  import char_buf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic upd_en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  gnt_t last_grant;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (req_a && (!req_b || last_grant == GNT_B)) begin
      gnt_a = 1'b1;
    end else if (req_b) begin
      gnt_b = 1'b1;
    end
  end

  // B is the reset value so that A wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_B;
    end else if (upd_en && gnt_a) begin
      last_grant <= GNT_A;
    end else if (upd_en && gnt_b) begin
      last_grant <= GNT_B;
    end
  end

endmodule

// File: rtl/char_wr_arbiter.sv
// Shares the character-buffer write port between writers A and B and runs a
// full-screen clear sequencer. Define CHAR_WR_ADDR_CHECK_EN to drop writes to
// out-of-range cells and flag them on err_oob.
module char_wr_arbiter
  import char_buf_pkg::*;
#(
  parameter int         COLS      = TEXT_COLS,
  parameter int         ROWS      = TEXT_ROWS,
  parameter int         ADDR_W    = TEXT_ADDR_W,
  parameter logic [7:0] FILL_CHAR = CHAR_SPACE
) (
  input  logic               clk,
  input  logic               rst,
  char_wr_arbiter_if.slave   bus
`ifdef CHAR_WR_ADDR_CHECK_EN
  ,
  output logic               err_oob
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              arb_en;
  logic              gnt_a, gnt_b, grant;
  logic              write_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_data;

  // A clear request in ARB blocks every grant in that same cycle
  assign arb_en = (state_q == ST_ARB) && !bus.clr_req;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .upd_en (arb_en),
    .req_a  (bus.a_valid & arb_en),
    .req_b  (bus.b_valid & arb_en),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b)
  );

  assign bus.a_ready = gnt_a;
  assign bus.b_ready = gnt_b;
  assign grant       = gnt_a | gnt_b;
  assign sel_addr    = gnt_b ? bus.b_addr : bus.a_addr;
  assign sel_data    = gnt_b ? bus.b_data : bus.a_data;

`ifdef CHAR_WR_ADDR_CHECK_EN
  localparam logic [ADDR_W:0] CELLS = (ADDR_W + 1)'(COLS * ROWS);
  logic oob;

  assign oob      = ({1'b0, sel_addr} >= CELLS);
  assign write_ok = grant && !oob;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_oob <= 1'b0;
    end else begin
      err_oob <= grant && oob;
    end
  end
`else
  assign write_ok = grant;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ARB: begin
        if (bus.clr_req) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // clr_cnt always equals the address currently presented on wr_addr in CLEAR
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt_q <= '0;
    end else if (state_q == ST_ARB) begin
      clr_cnt_q <= '0;
    end else if (state_d == ST_CLEAR) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  // Output register: one write per clock, addr/data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      bus.clr_busy <= 1'b0;
    end else begin
      unique case (state_q)
        ST_ARB: begin
          if (bus.clr_req) begin
            bus.wr_en    <= 1'b1;
            bus.wr_addr  <= '0;
            bus.wr_data  <= FILL_CHAR;
            bus.clr_busy <= 1'b1;
          end else begin
            bus.wr_en    <= write_ok;
            bus.clr_busy <= 1'b0;
            if (write_ok) begin
              bus.wr_addr <= sel_addr;
              bus.wr_data <= sel_data;
            end
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            bus.wr_en    <= 1'b0;
            bus.clr_busy <= 1'b0;
          end else begin
            bus.wr_en    <= 1'b1;
            bus.wr_addr  <= clr_cnt_q + 1'b1;
            bus.wr_data  <= FILL_CHAR;
            bus.clr_busy <= 1'b1;
          end
        end
        default: begin
          bus.wr_en    <= 1'b0;
          bus.clr_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_wr_arbiter.sv
// Directed bench for char_wr_arbiter; build with CHAR_WR_ADDR_CHECK_EN to
// exercise the out-of-range check.
module tb_char_wr_arbiter;
  import char_buf_pkg::*;

  logic clk;
  logic rst;
`ifdef CHAR_WR_ADDR_CHECK_EN
  logic err_oob;
`endif

  int checks   = 0;
  int failures = 0;

  char_wr_arbiter_if #(.ADDR_W(13)) bus ();

  char_wr_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef CHAR_WR_ADDR_CHECK_EN
    ,
    .err_oob (err_oob)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int bad;
    rst         = 1'b1;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.clr_req = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_wr_en",    32'(bus.wr_en),    32'd0);
    check("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
    check("rst_wr_data",  32'(bus.wr_data),  32'd0);
    check("rst_clr_busy", 32'(bus.clr_busy), 32'd0);
    check("rst_a_ready",  32'(bus.a_ready),  32'd0);
    check("rst_b_ready",  32'(bus.b_ready),  32'd0);

    // Single A write, latency 1
    bus.a_valid = 1'b1; bus.a_addr = 13'd5; bus.a_data = 8'h41;
    #1;
    check("a_only_ready", 32'(bus.a_ready), 32'd1);
    check("a_only_bnot",  32'(bus.b_ready), 32'd0);
    tick();
    bus.a_valid = 1'b0;
    check("a_only_wr_en", 32'(bus.wr_en),   32'd1);
    check("a_only_addr",  32'(bus.wr_addr), 32'd5);
    check("a_only_data",  32'(bus.wr_data), 32'h41);

    // Single B write; leaves last_grant at B
    bus.b_valid = 1'b1; bus.b_addr = 13'd7; bus.b_data = 8'h42;
    #1;
    check("b_only_ready", 32'(bus.b_ready), 32'd1);
    tick();
    bus.b_valid = 1'b0;
    check("b_only_addr", 32'(bus.wr_addr), 32'd7);
    check("b_only_data", 32'(bus.wr_data), 32'h42);

    // Both held for 4 cycles: A,B,A,B
    bus.a_valid = 1'b1; bus.a_addr = 13'd10; bus.a_data = 8'h61;
    bus.b_valid = 1'b1; bus.b_addr = 13'd20; bus.b_data = 8'h62;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_a_ready", 32'(bus.a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_b_ready", 32'(bus.b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check("rr_wr_en",   32'(bus.wr_en),   32'd1);
      check("rr_wr_addr", 32'(bus.wr_addr), (i % 2 == 0) ? 32'd10 : 32'd20);
      check("rr_wr_data", 32'(bus.wr_data), (i % 2 == 0) ? 32'h61 : 32'h62);
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick();
    check("idle_wr_en",   32'(bus.wr_en),   32'd0);
    check("idle_wr_addr", 32'(bus.wr_addr), 32'd20);

    // Clear request beats a pending A; A then waits out the clear
    bus.a_valid = 1'b1; bus.a_addr = 13'd33; bus.a_data = 8'h43;
    bus.clr_req = 1'b1;
    #1;
    check("clr_blocks_a", 32'(bus.a_ready), 32'd0);
    tick();
    bus.clr_req = 1'b0;
    bad = 0;
    for (int k = 0; k < TEXT_CELLS; k++) begin
      if (k == 2000) bus.clr_req = 1'b1;
      if (k == 2001) bus.clr_req = 1'b0;
      #1;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 13'(k) || bus.wr_data !== 8'h20 ||
          bus.clr_busy !== 1'b1 || bus.a_ready !== 1'b0) begin
        bad++;
        if (bad == 1) check("clr_cycle_first_bad", 32'(k), 32'hFFFF_FFFF);
      end
      tick();
    end
    check("clr_bad_cycles", 32'(bad), 32'd0);
    #1;
    check("clr_end_busy",  32'(bus.clr_busy), 32'd0);
    check("clr_end_wr_en", 32'(bus.wr_en),    32'd0);
    check("post_clr_a",    32'(bus.a_ready),  32'd1);
    tick();
    bus.a_valid = 1'b0;
    check("post_clr_addr", 32'(bus.wr_addr), 32'd33);
    check("post_clr_data", 32'(bus.wr_data), 32'h43);
    tick();
    check("post_clr_idle", 32'(bus.wr_en), 32'd0);

    // Reset in the middle of a clear
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    check("abort_cnt100", 32'(bus.wr_addr), 32'd100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_wr_en",   32'(bus.wr_en),    32'd0);
    check("abort_busy",    32'(bus.clr_busy), 32'd0);
    check("abort_wr_addr", 32'(bus.wr_addr),  32'd0);
    tick();
    check("abort_no_wr", 32'(bus.wr_en), 32'd0);
    bus.b_valid = 1'b1; bus.b_addr = 13'd44; bus.b_data = 8'h44;
    #1;
    check("abort_b_ready", 32'(bus.b_ready), 32'd1);
    tick();
    bus.b_valid = 1'b0;
    check("abort_b_addr", 32'(bus.wr_addr), 32'd44);

    // Last grant B: A wins tie, B withdraws and never writes
    bus.a_valid = 1'b1; bus.a_addr = 13'd50; bus.a_data = 8'h50;
    bus.b_valid = 1'b1; bus.b_addr = 13'd60; bus.b_data = 8'h60;
    #1;
    check("drop_a_ready", 32'(bus.a_ready), 32'd1);
    check("drop_b_ready", 32'(bus.b_ready), 32'd0);
    tick();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    check("drop_wr_addr", 32'(bus.wr_addr), 32'd50);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("drop_no_b_wr", {bus.wr_en, 19'd0, bus.wr_addr}, {1'b0, 19'd0, 13'd50});
    end

    // Address just past the last cell
    bus.a_valid = 1'b1; bus.a_addr = 13'd4800; bus.a_data = 8'h58;
    #1;
    check("oob_a_ready", 32'(bus.a_ready), 32'd1);
    tick();
    bus.a_valid = 1'b0;
`ifdef CHAR_WR_ADDR_CHECK_EN
    check("oob_wr_en",  32'(bus.wr_en), 32'd0);
    check("oob_err",    32'(err_oob),   32'd1);
    tick();
    check("oob_err_one", 32'(err_oob),  32'd0);
`else
    check("oob_wr_en",   32'(bus.wr_en),   32'd1);
    check("oob_wr_addr", 32'(bus.wr_addr), 32'd4800);
    check("oob_wr_data", 32'(bus.wr_data), 32'h58);
    tick();
`endif
    check("oob_after", 32'(bus.wr_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
